lsu_ctrl: RTL

// Load/store control stage between the execute stage and the byte-addressed data memory.
// - Accepts one load/store request per transaction through a valid/ready handshake.
// - Computes the effective address and checks alignment and range.
// - Drives the memory port for exactly one cycle, registers the read data and returns a response.
// - Misaligned, out-of-range or illegal requests never reach memory; they return with an error flag.

---
 rtl/lsu_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store control stage between the execute stage and a byte-addressed data
// memory. It accepts one request at a time and computes base + offset. It
// rejects illegal, misaligned or out-of-range accesses before they reach
// memory. Legal accesses drive the memory port for one cycle, and every request
// returns exactly one response.
//
// Ports
//   clk_i             clock, rising edge
//   rst_i             asynchronous reset, active-high
//   req_valid_i       request present
//   req_ready_o       request can be accepted (high only in IDLE)
//   req_we_i          1 = store, 0 = load
//   req_funct3_i      RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_base_i        rs1 value
//   req_offset_i      sign-extended immediate
//   req_wdata_i       store data (rs2)
//   resp_valid_o      response present
//   resp_ready_i      consumer accepts the response
//   resp_rdata_o      load result; 0 for stores and errored requests
//   resp_err_o        misaligned, out-of-range or illegal funct3
//   mem_addr_o        memory byte address (registered)
//   mem_wdata_o       memory write data (registered)
//   mem_rw_o          memory write enable (ACCESS cycle of a store only)
//   mem_size_type_o   memory size/sign code: [1:0] 10=byte 01=half 00=word,
//                     [2]=sign-extend
//   mem_rdata_i       asynchronous memory read data
// -----------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int MEM_BYTES = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [AWIDTH-1:0] req_base_i,
  input  logic [AWIDTH-1:0] req_offset_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DWIDTH-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_rw_o,
  output logic [2:0]        mem_size_type_o,
  input  logic [DWIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              we_q;
  logic [AWIDTH-1:0] mem_addr_q;
  logic [DWIDTH-1:0] mem_wdata_q;
  logic [2:0]        mem_size_q;
  logic [DWIDTH-1:0] resp_rdata_q;
  logic              resp_err_q;

  // Request decode
  logic [AWIDTH-1:0] eff_addr;
  logic [AWIDTH:0]   nbytes;
  logic [AWIDTH:0]   end_addr;
  logic [2:0]        size_code;
  logic              illegal;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic              accept;

  // Carry out of the address add is intentionally dropped.
  assign eff_addr = req_base_i + req_offset_i;

  always_comb begin
    size_code = 3'b000;
    nbytes    = '0;
    illegal   = 1'b0;
    case (req_funct3_i)
      3'b000: begin  // LB / SB
        size_code = req_we_i ? 3'b010 : 3'b110;
        nbytes    = (AWIDTH+1)'(1);
      end
      3'b001: begin  // LH / SH
        size_code = req_we_i ? 3'b001 : 3'b101;
        nbytes    = (AWIDTH+1)'(2);
      end
      3'b010: begin  // LW / SW
        size_code = 3'b000;
        nbytes    = (AWIDTH+1)'(4);
      end
      3'b100: begin  // LBU (no unsigned store exists)
        size_code = 3'b010;
        nbytes    = (AWIDTH+1)'(1);
        illegal   = req_we_i;
      end
      3'b101: begin  // LHU
        size_code = 3'b001;
        nbytes    = (AWIDTH+1)'(2);
        illegal   = req_we_i;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign misaligned = ((nbytes == (AWIDTH+1)'(2)) && eff_addr[0]) ||
                      ((nbytes == (AWIDTH+1)'(4)) && (eff_addr[1:0] != 2'b00));

  // One extra bit so an access that wraps past 2^AWIDTH cannot pass.
  assign end_addr     = {1'b0, eff_addr} + nbytes;
  assign out_of_range = end_addr > (AWIDTH+1)'(MEM_BYTES);

  assign req_err = illegal | misaligned | out_of_range;
  assign accept  = req_valid_i & (state_q == IDLE);

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_size_q   <= 3'b000;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        resp_err_q   <= req_err;
        resp_rdata_q <= '0;
        // The memory-side registers only change for accesses that reach
        // memory, so they hold their last values across rejected requests.
        if (!req_err) begin
          we_q        <= req_we_i;
          mem_addr_q  <= eff_addr;
          mem_wdata_q <= req_wdata_i;
          mem_size_q  <= size_code;
        end
      end
      // Memory applies the sign/zero extension; data is taken unchanged.
      if ((state_q == ACCESS) && !we_q) begin
        resp_rdata_q <= mem_rdata_i;
      end
    end
  end

  // Next state and state-decoded outputs. mem_rw and resp_valid come straight
  // from the state register so they drop the moment reset is asserted.
  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    mem_rw_o     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        mem_rw_o = we_q;
        state_d  = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr_o      = mem_addr_q;
  assign mem_wdata_o     = mem_wdata_q;
  assign mem_size_type_o = mem_size_q;
  assign resp_rdata_o    = resp_rdata_q;
  assign resp_err_o      = resp_err_q;

endmodule
